io_sw_debounce: RTL and testbench

//   Input conditioner for the board slide switches. Sits directly upstream of the processor's
//   i_io_sw port. Synchronises asynchronous raw switch levels and debounces each bit

---
 rtl/io_pkg.sv | 18 +
 rtl/sw_debounce_bit.sv | 87 ++++++++
 rtl/io_sw_debounce.sv | 70 +++++++
 tb/tb_io_sw_debounce.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and constants for the slide-switch input conditioner.
package io_pkg;

   // Board slide-switch count as seen by the core's i_io_sw port.
   localparam int unsigned IO_SW_WIDTH = 32;

   // Per-bit debounce state: IDLE waits for a difference, COUNT times its persistence.
   typedef enum logic {
      SW_IDLE  = 1'b0,
      SW_COUNT = 1'b1
   } sw_state_e;

   // Debounce counter width; DEBOUNCE_CYCLES=1 still needs one bit to hold a zero count.
   function automatic int unsigned sw_cnt_width(input int unsigned cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: SYNC_STAGES-deep synchroniser, persistence counter and IDLE/COUNT FSM.
// o_accept is the combinational acceptance strobe; o_sw updates on the same edge.
module sw_debounce_bit
   import io_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_sw_raw,
   output logic o_sw,
   output logic o_accept
);

   localparam int unsigned CntW = sw_cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   sw_state_e              state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   sw_q, sw_d;
   logic                   accept;

   // Synchroniser chain: bit 0 takes the raw level, top bit feeds the FSM.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_sw_raw};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // State, counter and accepted level registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= SW_IDLE;
         cnt_q   <= '0;
         sw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sw_q    <= sw_d;
      end
   end

   // Next-state: any return to the accepted level restarts the count from zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sw_d    = sw_q;
      accept  = 1'b0;
      unique case (state_q)
         SW_IDLE: begin
            if (s != sw_q) begin
               state_d = SW_COUNT;
               cnt_d   = '0;
            end
         end
         SW_COUNT: begin
            if (s == sw_q) begin
               state_d = SW_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               // Cleared here so the counter never wraps.
               sw_d    = s;
               accept  = 1'b1;
               state_d = SW_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = SW_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign o_sw     = sw_q;
   assign o_accept = accept;

endmodule

// File: rtl/io_sw_debounce.sv
// Slide-switch conditioner feeding the core's i_io_sw port: per-bit synchronise and debounce,
// with a one-cycle o_sw_changed pulse on every accepted change.
// Optional macro SW_EDGE_LATCH_EN adds sticky per-bit edge flags (o_sw_edge) cleared by
// i_edge_clr; a set and a clear in the same cycle leave the flag set.
module io_sw_debounce
   import io_pkg::*;
#(
   parameter int unsigned WIDTH           = IO_SW_WIDTH,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_sw_raw,
   output logic [WIDTH-1:0] o_io_sw,
`ifdef SW_EDGE_LATCH_EN
   input  logic [WIDTH-1:0] i_edge_clr,
   output logic [WIDTH-1:0] o_sw_edge,
`endif
   output logic [WIDTH-1:0] o_sw_changed
);

   logic [WIDTH-1:0] accept;
   logic [WIDTH-1:0] changed_q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sw_debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .i_clk    (i_clk),
         .i_reset  (i_reset),
         .i_sw_raw (i_sw_raw[i]),
         .o_sw     (o_io_sw[i]),
         .o_accept (accept[i])
      );
   end

   // Change pulse: registered acceptance strobe, aligned with the o_io_sw update.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         changed_q <= '0;
      end else begin
         changed_q <= accept;
      end
   end

   assign o_sw_changed = changed_q;

`ifdef SW_EDGE_LATCH_EN
   logic [WIDTH-1:0] edge_q, edge_d;

   // Sticky edge flags: set wins over clear so no acceptance is ever lost.
   always_comb begin
      edge_d = (edge_q & ~i_edge_clr) | accept;
   end

   // Edge flag register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         edge_q <= '0;
      end else begin
         edge_q <= edge_d;
      end
   end

   assign o_sw_edge = edge_q;
`endif

endmodule

// File: tb/tb_io_sw_debounce.sv
// Directed bench for io_sw_debounce (WIDTH=32, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// A level presented before edge 0 is expected on o_io_sw after edge 6.
module tb_io_sw_debounce;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] raw = '0;
   logic [W-1:0] io_sw;
   logic [W-1:0] changed;
`ifdef SW_EDGE_LATCH_EN
   logic [W-1:0] edge_clr = '0;
   logic [W-1:0] sw_edge;
`endif

   int n_cmp = 0;
   int n_err = 0;

   io_sw_debounce #(
      .WIDTH           (W),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_sw_raw     (raw),
      .o_io_sw      (io_sw),
`ifdef SW_EDGE_LATCH_EN
      .i_edge_clr   (edge_clr),
      .o_sw_edge    (sw_edge),
`endif
      .o_sw_changed (changed)
   );

   always #5 clk = ~clk;

   // Advance one rising edge; inputs and outputs are handled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [W-1:0] level);
      raw = level;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [W-1:0] exp_sw, exp_ch;
      raw = '1;
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (io_sw !== '0) begin
            n_err++;
            $display("FAIL reset_sw[%0d]: got %h expected %h", i, io_sw, 32'h0);
         end
         n_cmp++;
         if (changed !== '0) begin
            n_err++;
            $display("FAIL reset_ch[%0d]: got %h expected %h", i, changed, 32'h0);
         end
      end
      rst = 1'b0;
      for (int j = 0; j < 8; j++) begin
         tick();
         exp_sw = (j >= 6) ? '1 : '0;
         exp_ch = (j == 6) ? '1 : '0;
         n_cmp++;
         if (io_sw !== exp_sw) begin
            n_err++;
            $display("FAIL release_sw[%0d]: got %h expected %h", j, io_sw, exp_sw);
         end
         n_cmp++;
         if (changed !== exp_ch) begin
            n_err++;
            $display("FAIL release_ch[%0d]: got %h expected %h", j, changed, exp_ch);
         end
      end
   endtask

   task automatic test_glitch();
      do_reset('0);
      for (int j = 0; j < 15; j++) begin
         raw = (j < 3) ? 32'h1 : 32'h0;
         tick();
         n_cmp++;
         if (io_sw !== 32'h0 || changed !== 32'h0) begin
            n_err++;
            $display("FAIL glitch[%0d]: got sw=%h ch=%h expected sw=%h ch=%h",
                     j, io_sw, changed, 32'h0, 32'h0);
         end
      end
   endtask

   task automatic test_clean_press();
      logic [W-1:0] exp_sw, exp_ch;
      raw = 32'h20;
      for (int j = 0; j < 10; j++) begin
         tick();
         exp_sw = (j >= 6) ? 32'h20 : 32'h0;
         exp_ch = (j == 6) ? 32'h20 : 32'h0;
         n_cmp++;
         if (io_sw !== exp_sw || changed !== exp_ch) begin
            n_err++;
            $display("FAIL press[%0d]: got sw=%h ch=%h expected sw=%h ch=%h",
                     j, io_sw, changed, exp_sw, exp_ch);
         end
      end
   endtask

   task automatic test_bounce();
      logic [W-1:0] exp_sw, exp_ch;
      int pulses = 0;
      // j=0..7 toggle 1,0,1,0,...; last toggle to 1 at j=8, held; accept at j=14.
      for (int j = 0; j < 18; j++) begin
         raw = 32'h20;
         raw[3] = (j < 8) ? ~j[0] : 1'b1;
         tick();
         exp_sw = (j >= 14) ? 32'h28 : 32'h20;
         exp_ch = (j == 14) ? 32'h08 : 32'h0;
         if (changed[3]) pulses++;
         n_cmp++;
         if (io_sw !== exp_sw || changed !== exp_ch) begin
            n_err++;
            $display("FAIL bounce[%0d]: got sw=%h ch=%h expected sw=%h ch=%h",
                     j, io_sw, changed, exp_sw, exp_ch);
         end
      end
      n_cmp++;
      if (pulses != 1) begin
         n_err++;
         $display("FAIL bounce_pulses: got %0d expected %0d", pulses, 1);
      end
   endtask

   task automatic test_mid_reset();
      logic [W-1:0] exp_sw, exp_ch;
      // Bits 3 and 5 start releasing too, but the reset lands before they are accepted.
      raw = 32'h80;
      for (int j = 0; j < 4; j++) begin
         tick();
         n_cmp++;
         if (io_sw !== 32'h28 || changed !== 32'h0) begin
            n_err++;
            $display("FAIL midrst_pre[%0d]: got sw=%h ch=%h expected sw=%h ch=%h",
                     j, io_sw, changed, 32'h28, 32'h0);
         end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if (io_sw !== 32'h0 || changed !== 32'h0) begin
         n_err++;
         $display("FAIL midrst_rst: got sw=%h ch=%h expected sw=%h ch=%h",
                  io_sw, changed, 32'h0, 32'h0);
      end
      for (int j = 0; j < 10; j++) begin
         tick();
         exp_sw = (j >= 6) ? 32'h80 : 32'h0;
         exp_ch = (j == 6) ? 32'h80 : 32'h0;
         n_cmp++;
         if (io_sw !== exp_sw || changed !== exp_ch) begin
            n_err++;
            $display("FAIL midrst_post[%0d]: got sw=%h ch=%h expected sw=%h ch=%h",
                     j, io_sw, changed, exp_sw, exp_ch);
         end
      end
   endtask

`ifdef SW_EDGE_LATCH_EN
   task automatic test_edge_latch();
      logic [W-1:0] exp_edge;
      do_reset('0);
      edge_clr = '0;
      raw = 32'h4;
      for (int j = 0; j < 10; j++) begin
         tick();
         exp_edge = (j >= 6) ? 32'h4 : 32'h0;
         n_cmp++;
         if (sw_edge !== exp_edge) begin
            n_err++;
            $display("FAIL edge_set[%0d]: got %h expected %h", j, sw_edge, exp_edge);
         end
      end
      // Release bit 2; clear coincides with its acceptance edge.
      raw = 32'h0;
      for (int j = 0; j < 7; j++) begin
         edge_clr = (j == 6) ? 32'h4 : 32'h0;
         tick();
         n_cmp++;
         if (sw_edge !== 32'h4) begin
            n_err++;
            $display("FAIL edge_hold[%0d]: got %h expected %h", j, sw_edge, 32'h4);
         end
      end
      edge_clr = '0;
      n_cmp++;
      if (changed !== 32'h4 || io_sw !== 32'h0) begin
         n_err++;
         $display("FAIL edge_accept: got sw=%h ch=%h expected sw=%h ch=%h",
                  io_sw, changed, 32'h0, 32'h4);
      end
      tick();
      tick();
      n_cmp++;
      if (sw_edge !== 32'h4) begin
         n_err++;
         $display("FAIL edge_sticky: got %h expected %h", sw_edge, 32'h4);
      end
      edge_clr = 32'h4;
      tick();
      edge_clr = '0;
      n_cmp++;
      if (sw_edge !== 32'h0) begin
         n_err++;
         $display("FAIL edge_clear: got %h expected %h", sw_edge, 32'h0);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_glitch();
      test_clean_press();
      test_bounce();
      test_mid_reset();
`ifdef SW_EDGE_LATCH_EN
      test_edge_latch();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Run guard: stimulus is fixed-length, so this only fires if the bench stalls.
   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish before %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
